instr_fetch_resp: RTL
=====================

INSTR_FETCH_RESP -- requirements
Module: instr_fetch_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) clears all control state immediately.
REQ-004 req_valid  input  1  fetch request present.
REQ-005 req_addr  input  5  word address of the requested instruction (program-counter value).
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 rsp_valid  output  1  response word present.
REQ-008 rsp_data  output  32  instruction word.
REQ-009 rsp_addr  output  5  address the response belongs to.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 ld_en  input  1  instruction-memory load strobe.
REQ-012 ld_addr  input  5  load address.
REQ-013 ld_data  input  32  load data.

Function
REQ-014 Storage SHALL be 32 words x 32 bits, with one word per 5-bit address and no address wrap logic needed.
REQ-015 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1.
REQ-016 The array read SHALL be synchronous: request accepted in cycle N means the data enters the 2-entry response FIFO at the end of cycle N+1, and rsp_valid is 1 in cycle N+1 at the earliest.
REQ-017 req_ready SHALL be 1 only when ld_en is 0 and the FIFO count plus in-flight reads is less than 2; no response is ever dropped.
REQ-018 Responses SHALL be returned strictly in request order.
REQ-019 rsp_valid, rsp_data and rsp_addr SHALL stay stable while rsp_valid is 1 and rsp_ready is 0.
REQ-020 Accepting a request and popping a response in the same cycle SHALL be legal; with the FIFO full and a pop in progress, req_ready stays 0 that cycle (no combinational ready path from rsp_ready).
REQ-021 ld_en SHALL take priority over requests: while ld_en is 1, req_ready is 0 and the word is written at the clock edge.
REQ-022 An in-flight read to the address being loaded SHALL return the pre-load word (read-before-write).
REQ-023 The control FSM SHALL have states IDLE (FIFO empty, nothing in flight), ACTIVE (reads in flight or FIFO occupied), and FULL (count plus in-flight equals 2).
REQ-024 FSM transitions SHALL be fully determined by the accept/pop/load events of REQ-015 to REQ-021; an illegal state encoding SHALL recover to IDLE.

Reset
REQ-025 While reset is 0, the outputs SHALL be: req_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0; the FIFO is emptied and the FSM is in IDLE.
REQ-026 req_ready SHALL go to 1 in the first clock cycle after reset deasserts, unless ld_en is 1.
REQ-027 A reset asserted mid-operation SHALL discard in-flight reads and FIFO contents.
REQ-028 The memory array SHALL NOT be reset, so loaded words survive reset.

Configuration
REQ-029 With IFR_PARITY_EN defined, each word SHALL store an even-parity bit computed at load time, and an extra output rsp_err (1 bit, reset 0) SHALL assert alongside rsp_valid when the read parity mismatches.
REQ-030 Without IFR_PARITY_EN, there SHALL be no parity storage and no rsp_err port.

Structure
REQ-031 A shared package instr_fetch_pkg SHALL hold: ADDR_W=5, DATA_W=32, MEM_DEPTH=32, RSP_FIFO_DEPTH=2, the FSM state enum, and the rsp_t struct (addr, data, err).
REQ-032 The 2-entry response FIFO SHALL be the sub-module ifr_rsp_fifo; the array and FSM stay in the top module.

Verification
REQ-033 Scenario 1: load addr 3 = 0xDEADBEEF, then request addr 3 with rsp_ready=1 -> rsp_valid in the next cycle, rsp_data=0xDEADBEEF, rsp_addr=3.
REQ-034 Scenario 2: rsp_ready=0 and requests to addresses 0, 1, 2 back-to-back -> two are accepted, req_ready=0 on the third, and responses for 0 then 1 hold stable until popped.
REQ-035 Scenario 3: ld_en=1 held for 3 cycles while req_valid=1 -> req_ready=0 for those cycles, and the first accept happens in the cycle after ld_en falls.
REQ-036 Scenario 4: request addr 7 accepted, with a load of addr 7 = 0x1 in the next cycle -> the response carries the old word; a following request to 7 returns 0x1.
REQ-037 Scenario 5: reset pulsed low with the FIFO full -> rsp_valid=0 immediately, req_ready=1 in the first cycle after release, and previously loaded words are still readable.
REQ-038 Scenario 6 (IFR_PARITY_EN): force a flip of a stored bit at addr 5, then request 5 -> rsp_err=1 with rsp_valid; a clean word gives rsp_err=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and sizes for the instruction fetch response path.
// Optional build macro: IFR_PARITY_EN (per-word even parity, rsp_err port).
package instr_fetch_pkg;

  localparam int ADDR_W         = 5;
  localparam int DATA_W         = 32;
  localparam int MEM_DEPTH      = 32;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } ifr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ifr_rsp_fifo.sv
// Two-entry response FIFO with bypass of the read stage when empty.
// Optional build macro: none (parity handled by instr_fetch_resp).
module ifr_rsp_fifo
  import instr_fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rsp_t push_data_i,
  input  logic pop_i,
  output logic valid_o,
  output rsp_t head_o
);

  rsp_t       ent_q [RSP_FIFO_DEPTH];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;

  logic has;
  logic do_pop;
  logic do_push;

  assign has = (cnt_q != 2'd0);
  assign do_pop = pop_i & has;
  // An empty FIFO hands the read word straight out; it only
  // needs storing if the consumer does not take it now.
  assign do_push = push_i & ~(~has & pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        ent_q[wr_q] <= push_data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = has | push_i;

  always_comb begin
    head_o = '0;
    if (has) begin
      head_o = ent_q[rd_q];
    end else if (push_i) begin
      head_o = push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction memory with synchronous read, load port and in-order responses.
// Optional build macro: IFR_PARITY_EN adds stored parity and rsp_err.
module instr_fetch_resp
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              rsp_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`ifdef IFR_PARITY_EN
  ,
  output logic              rsp_err
`endif
);

`ifdef IFR_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [MEM_DEPTH];
  logic [MEM_W-1:0]  ld_word;
  logic [MEM_W-1:0]  rd_word_q;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_err;

  ifr_state_e state_q;
  ifr_state_e state_d;

  logic acc;
  logic pop;
  rsp_t push_rsp;
  rsp_t head;
  logic f_valid;

`ifdef IFR_PARITY_EN
  assign ld_word = {even_par(ld_data), ld_data};
  assign rd_err  = rd_word_q[DATA_W] ^ even_par(rd_word_q[DATA_W-1:0]);
`else
  assign ld_word = ld_data;
  assign rd_err  = 1'b0;
`endif

  // Array is deliberately not reset so loaded code survives reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_word;
    end
    if (acc) begin
      rd_word_q <= mem_q[req_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      rd_vld_q  <= acc;
      if (acc) begin
        rd_addr_q <= req_addr;
      end
      state_q <= state_d;
    end
  end

  // Ready depends only on registered state, never on rsp_ready.
  assign req_ready = reset & ~ld_en &
                     ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign acc = req_valid & req_ready;
  assign pop = rsp_valid & rsp_ready;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        state_d = acc ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: begin
        if (acc && !pop) begin
          state_d = ST_FULL;
        end else if (!acc && pop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FULL: begin
        state_d = pop ? ST_ACTIVE : ST_FULL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign push_rsp = '{addr: rd_addr_q,
                      data: rd_word_q[DATA_W-1:0],
                      err:  rd_err};

  ifr_rsp_fifo u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (rd_vld_q),
    .push_data_i (push_rsp),
    .pop_i       (rsp_ready),
    .valid_o     (f_valid),
    .head_o      (head)
  );

  assign rsp_valid = f_valid;
  assign rsp_data  = head.data;
  assign rsp_addr  = head.addr;

`ifdef IFR_PARITY_EN
  assign rsp_err = head.err & f_valid;
`else
  logic unused_err;
  assign unused_err = head.err;
`endif

endmodule
